// File: rtl/memory_arb_pkg.sv
// rtl/memory_arb_pkg.sv - shared types and default sizes for the memory arbiter
package memory_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_SIZE   = 16;
  localparam int DEF_TIMEOUT    = 15;
  localparam int DEF_IDX_W      = $clog2(DEF_NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    ERR
  } arb_state_t;

  typedef struct packed {
    logic                      wr;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
    logic [DEF_IDX_W-1:0]      idx;
  } cmd_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - requester and memory-port signal bundle of the arbiter
interface memory_arbiter_if
  import memory_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic                          rsp_err;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          mem_wr;
  logic                          mem_rd;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          mem_slv_rsp;

  // master = the arbiter itself; slave = requesters plus memory model
  modport master (
    input  req, req_wr, req_addr, req_wdata, mem_rdata, mem_slv_rsp,
    output gnt, rsp_valid, rsp_err, rsp_rdata, mem_wr, mem_rd, mem_addr, mem_wdata
  );

  modport slave (
    output req, req_wr, req_addr, req_wdata, mem_rdata, mem_slv_rsp,
    input  gnt, rsp_valid, rsp_err, rsp_rdata, mem_wr, mem_rd, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first set request at or after ptr
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin : pick
    int                 j;
    logic [IDX_W-1:0]   sel;
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    j      = 0;
    sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // explicit wrap so non-power-of-2 NUM_REQ never indexes past the top requester
      j = int'(i_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sel = IDX_W'(j);
      if (!o_any && i_req[sel]) begin
        o_any       = 1'b1;
        o_idx       = sel;
        o_pick[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter sharing one memory port, with timeout and range check
module memory_arbiter
  import memory_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic              clk,
  input logic              reset,
  memory_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t            r_state;
  cmd_t                  r_cmd;
  logic [NUM_REQ-1:0]    r_sel;
  logic [IDX_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_mem_wr;
  logic                  r_mem_rd;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic [NUM_REQ-1:0]    w_pick;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_ptr_next;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_pick(w_pick),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_wr       = bus.req_wr[w_idx];
  assign w_addr     = bus.req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata    = bus.req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_in_range = 32'(w_addr) < MEM_SIZE;
  assign w_ptr_next = (r_cmd.idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_cmd.idx + 1'b1;

  // Outputs are registered on entry to a state, so they are visible during that state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_sel       <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_cmd.wr    <= w_wr;
            r_cmd.addr  <= w_addr;
            r_cmd.wdata <= w_wdata;
            r_cmd.idx   <= w_idx;
            r_sel       <= w_pick;
            r_gnt       <= w_pick;
            if (w_in_range) begin
              r_mem_wr    <= w_wr;
              r_mem_rd    <= !w_wr;
              r_mem_addr  <= w_addr;
              r_mem_wdata <= w_wdata;
              r_state     <= ISSUE;
            end else begin
              r_rsp_valid <= w_pick;
              r_rsp_err   <= 1'b1;
              r_state     <= ERR;
            end
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.mem_slv_rsp) begin
            r_rsp_valid <= r_sel;
            r_rsp_rdata <= r_cmd.wr ? '0 : bus.mem_rdata;
            r_state     <= RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            // TIMEOUT wait cycles elapsed: error lands TIMEOUT+1 cycles after the strobe
            r_rsp_valid <= r_sel;
            r_rsp_err   <= 1'b1;
            r_state     <= ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP, ERR: begin
          r_ptr   <= w_ptr_next;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter with a queue-based reference model
module tb_memory_arbiter;
  import memory_arb_pkg::*;

  localparam int N    = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MS   = 16;
  localparam int TO   = 15;
  localparam int DEAD = 13;
  localparam int K_OK  = 0;
  localparam int K_OOR = 1;
  localparam int K_TMO = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  memory_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  typedef struct {
    int            idx;
    bit            err;
    logic [DW-1:0] rdata;
    int            kind;
  } rsp_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } stb_t;

  int   exp_gnt[$];
  rsp_t exp_rsp[$];
  stb_t exp_stb[$];

  logic [DW-1:0] ref_mem[MS];
  logic [DW-1:0] resp_mem[MS];
  bit            b_wr[N];
  logic [AW-1:0] b_addr[N];
  logic [DW-1:0] b_wdata[N];

  int m_ptr = 0;
  int checks = 0;
  int errors = 0;
  int rsp_delay = 0;
  int last_stb_cyc = 0;
  int last_slv_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant, strobe or response.
  stb_t ms;
  rsp_t mr;
  int   mg;
  always @(negedge clk) begin
    if (reset) begin
      if (bus.mem_slv_rsp) last_slv_cyc = cyc;
      if (bus.mem_wr || bus.mem_rd) begin
        chk("strobe_exclusive", 64'(bus.mem_wr & bus.mem_rd), 64'(0));
        last_stb_cyc = cyc;
        if (exp_stb.size() == 0) chk("strobe_unexpected", 64'(1), 64'(0));
        else begin
          ms = exp_stb.pop_front();
          chk("strobe_wr", 64'(bus.mem_wr), 64'(ms.wr));
          chk("strobe_addr", 64'(bus.mem_addr), 64'(ms.addr));
          if (ms.wr) chk("strobe_wdata", 64'(bus.mem_wdata), 64'(ms.wdata));
        end
      end
      if (bus.gnt != 0) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(bus.gnt), 64'(0));
        else begin
          mg = exp_gnt.pop_front();
          chk("gnt_order", 64'(bus.gnt), 64'(1) << mg);
        end
      end
      if (bus.rsp_valid != 0) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
        else begin
          mr = exp_rsp.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(1) << mr.idx);
          chk("rsp_err", 64'(bus.rsp_err), 64'(mr.err));
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(mr.rdata));
          if (mr.kind == K_OOR) chk("oor_gnt_same_cycle", 64'(bus.gnt), 64'(1) << mr.idx);
          else if (mr.kind == K_TMO) chk("timeout_latency", 64'(cyc - last_stb_cyc), 64'(TO + 1));
          else chk("rsp_latency", 64'(cyc - last_slv_cyc), 64'(1));
        end
      end
    end
  end

  // Memory model: answers every strobe except to the dead address.
  initial begin : responder
    int d;
    bit w;
    int a;
    bus.mem_slv_rsp = 1'b0;
    bus.mem_rdata   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset && (bus.mem_wr || bus.mem_rd) && bus.mem_addr != AW'(DEAD) && int'(bus.mem_addr) < MS) begin
        w = bus.mem_wr;
        a = int'(bus.mem_addr);
        if (w) resp_mem[a] = bus.mem_wdata;
        d = (rsp_delay != 0) ? rsp_delay : int'($urandom_range(1, 5));
        repeat (d) @(posedge clk);
        #1;
        bus.mem_slv_rsp = 1'b1;
        bus.mem_rdata   = w ? DW'($urandom) : resp_mem[a];
        @(posedge clk);
        #1;
        bus.mem_slv_rsp = 1'b0;
        bus.mem_rdata   = DW'($urandom);
      end
    end
  end

  // Reference: a batch raised together is served in ring order starting at the pointer.
  task automatic model_batch(input logic [N-1:0] mask);
    int   i;
    int   last;
    rsp_t r;
    stb_t s;
    last = m_ptr;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (mask[i]) begin
        last = i;
        exp_gnt.push_back(i);
        r.idx = i; r.err = 1'b0; r.rdata = '0; r.kind = K_OK;
        if (int'(b_addr[i]) >= MS) begin
          r.err = 1'b1; r.kind = K_OOR;
        end else begin
          s.wr = b_wr[i]; s.addr = b_addr[i]; s.wdata = b_wdata[i];
          exp_stb.push_back(s);
          if (int'(b_addr[i]) == DEAD) begin
            r.err = 1'b1; r.kind = K_TMO;
          end else if (b_wr[i]) ref_mem[b_addr[i]] = b_wdata[i];
          else r.rdata = ref_mem[b_addr[i]];
        end
        exp_rsp.push_back(r);
      end
    end
    m_ptr = (last + 1) % N;
  endtask

  task automatic drive_cmds();
    for (int i = 0; i < N; i++) begin
      bus.req_wr[i]             = b_wr[i];
      bus.req_addr[i*AW +: AW]  = b_addr[i];
      bus.req_wdata[i*DW +: DW] = b_wdata[i];
    end
  endtask

  task automatic run_batch(input logic [N-1:0] mask);
    bit done;
    done = 1'b0;
    model_batch(mask);
    drive_cmds();
    bus.req = mask;
    for (int t = 0; t < 400 && !done; t++) begin
      @(posedge clk);
      #1;
      bus.req = bus.req & ~bus.gnt;
      if (bus.req == 0 && exp_rsp.size() == 0) done = 1'b1;
    end
    if (!done) begin
      chk("batch_complete", 64'(0), 64'(1));
      bus.req = '0;
      exp_gnt.delete(); exp_rsp.delete(); exp_stb.delete();
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_gnt"}, 64'(bus.gnt), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(0));
    chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(0));
    chk({tag, "_mem_wr"}, 64'(bus.mem_wr), 64'(0));
    chk({tag, "_mem_rd"}, 64'(bus.mem_rd), 64'(0));
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
  endtask

  task automatic rand_cmd(input int i);
    int r;
    b_wr[i]    = 1'($urandom);
    b_wdata[i] = DW'($urandom);
    r = int'($urandom_range(0, 19));
    b_addr[i] = (r < MS) ? AW'(r) : AW'($urandom_range(MS, 255));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit got;
    bus.req = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < MS; i++) begin
      ref_mem[i]  = 32'hA500_0000 + DW'(i);
      resp_mem[i] = 32'hA500_0000 + DW'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // contention: all four write addr=i, twice; ring wraps back to requester 0
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < N; i++) begin
        b_wr[i] = 1'b1; b_addr[i] = AW'(i); b_wdata[i] = 32'hC0DE_0000 + DW'(rep * 16 + i);
      end
      run_batch(4'b1111);
    end

    // single read of addr 5, memory answers 2 cycles after the strobe
    ref_mem[5] = 32'hDEAD_BEEF; resp_mem[5] = 32'hDEAD_BEEF;
    b_wr[1] = 1'b0; b_addr[1] = 8'd5;
    rsp_delay = 2;
    run_batch(4'b0010);
    rsp_delay = 0;

    // out of range
    b_wr[2] = 1'b1; b_addr[2] = 8'd16; b_wdata[2] = 32'h0BAD_0BAD;
    run_batch(4'b0100);

    // timeout on a read, then a normal request
    b_wr[3] = 1'b0; b_addr[3] = AW'(DEAD);
    run_batch(4'b1000);
    b_wr[0] = 1'b0; b_addr[0] = 8'd1;
    run_batch(4'b0001);

    // write then read the same address
    b_wr[0] = 1'b1; b_addr[0] = 8'd3; b_wdata[0] = 32'h1234_5678;
    run_batch(4'b0001);
    b_wr[0] = 1'b0;
    run_batch(4'b0001);

    // reset while waiting on a dead address
    b_wr[0] = 1'b0; b_addr[0] = AW'(DEAD);
    exp_gnt.push_back(0);
    exp_stb.push_back('{wr: 1'b0, addr: AW'(DEAD), wdata: b_wdata[0]});
    drive_cmds();
    bus.req = 4'b0001;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(posedge clk);
      #1;
      if (bus.gnt[0]) got = 1'b1;
    end
    chk("reset_test_gnt_seen", 64'(got), 64'(1));
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_gnt.delete(); exp_rsp.delete(); exp_stb.delete();
    m_ptr = 0;
    chk_outputs_zero("midwait_reset");
    b_wr[1] = 1'b1; b_addr[1] = 8'd2; b_wdata[1] = 32'hFEED_0001;
    b_wr[3] = 1'b0; b_addr[3] = 8'd2;
    run_batch(4'b1010);

    // randomized batches
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) rand_cmd(i);
      run_batch(N'($urandom_range(1, (1 << N) - 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queues_drained", 64'(exp_gnt.size() + exp_rsp.size() + exp_stb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
